// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between an issuing client and alu_issue_ctrl.
// The slave modport is the controller's view; the master modport is the client's view.
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic        out_error;

  modport slave (
    input  in_valid, in_opcode, in_funct, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_overflow, out_error
  );

  modport master (
    output in_valid, in_opcode, in_funct, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_overflow, out_error
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU front end: decodes a MIPS opcode/funct pair into an ALU
// control code, drives registered operands to an external registered ALU,
// captures its result and flags, and presents them on a valid/ready response.
// Only one operation is ever in flight; decode errors skip the ALU entirely.
module alu_issue_ctrl #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  alu_issue_ctrl_if.slave        bus,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [3:0]             alu_control,
  input  logic [31:0]            alu_result,
  input  logic                   alu_zero,
  input  logic                   alu_overflow,
  input  logic                   alu_invalid,
  output logic [COUNT_WIDTH-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  w_ctrl;
  logic        w_decErr;
  logic        w_maskOvf;
  logic        w_accept;
  logic        w_respDone;
  logic        r_maskOvf;
  logic [31:0] r_outResult;
  logic        r_outZero;
  logic        r_outOverflow;
  logic        r_outError;

  assign w_accept   = (r_state == IDLE) && bus.in_valid;
  assign w_respDone = (r_state == RESP) && bus.out_ready;

  assign bus.in_ready     = (r_state == IDLE);
  assign bus.out_valid    = (r_state == RESP);
  assign bus.out_result   = r_outResult;
  assign bus.out_zero     = r_outZero;
  assign bus.out_overflow = r_outOverflow;
  assign bus.out_error    = r_outError;

  // Decode opcode/funct into an ALU control code; unsigned ops (addu/addiu/subu) mask overflow.
  always_comb begin
    w_ctrl    = 4'h0;
    w_decErr  = 1'b0;
    w_maskOvf = 1'b0;
    if (bus.in_opcode == 6'h00) begin
      case (bus.in_funct)
        6'h20:   w_ctrl = 4'h2;
        6'h21:   w_ctrl = 4'h3;
        6'h22:   w_ctrl = 4'h6;
        6'h23: begin
          w_ctrl    = 4'h6;
          w_maskOvf = 1'b1;
        end
        6'h24:   w_ctrl = 4'h0;
        6'h25:   w_ctrl = 4'h1;
        6'h27:   w_ctrl = 4'hC;
        6'h2A:   w_ctrl = 4'h7;
        default: w_decErr = 1'b1;
      endcase
    end else begin
      case (bus.in_opcode)
        6'h08:   w_ctrl = 4'h2;
        6'h09:   w_ctrl = 4'h3;
        6'h0C:   w_ctrl = 4'h0;
        6'h0D:   w_ctrl = 4'h1;
        6'h0A:   w_ctrl = 4'h7;
        6'h04:   w_ctrl = 4'h6;
        6'h05:   w_ctrl = 4'h6;
        6'h23:   w_ctrl = 4'h2;
        6'h2B:   w_ctrl = 4'h2;
        default: w_decErr = 1'b1;
      endcase
    end
    if (w_ctrl == 4'h3) begin
      w_maskOvf = 1'b1;
    end
  end

  // Next-state logic: decode errors go straight to the response state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = w_decErr ? RESP : EXEC;
      EXEC:    w_next = CAPTURE;
      CAPTURE: w_next = RESP;
      RESP:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand issue and response capture; ALU operands only change on a valid accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_a         <= 32'h0;
      alu_b         <= 32'h0;
      alu_control   <= 4'h0;
      r_maskOvf     <= 1'b0;
      r_outResult   <= 32'h0;
      r_outZero     <= 1'b0;
      r_outOverflow <= 1'b0;
      r_outError    <= 1'b0;
    end else if (w_accept && !w_decErr) begin
      alu_a       <= bus.in_a;
      alu_b       <= bus.in_b;
      alu_control <= w_ctrl;
      r_maskOvf   <= w_maskOvf;
    end else if (w_accept && w_decErr) begin
      r_outResult   <= 32'h0;
      r_outZero     <= 1'b0;
      r_outOverflow <= 1'b0;
      r_outError    <= 1'b1;
    end else if (r_state == CAPTURE) begin
      r_outResult   <= alu_result;
      r_outZero     <= alu_zero;
      r_outOverflow <= alu_overflow && !r_maskOvf;
      r_outError    <= alu_invalid;
    end
  end

  // Completed-response counter, wraps naturally at its width.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_count <= '0;
    end else if (w_respDone) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural registered ALU.
// A 2-bit counter width is used so the count wraps during the vector table.
module tb_alu_issue_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_invalid;
  logic [1:0]  op_count;
  logic        injInvalid;

  logic [31:0] mRes;
  logic        mOvf;
  logic        mInv;
  logic [32:0] mWide;

  int vectorsApplied;
  int miscompares;
  int expCount;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.COUNT_WIDTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_invalid  (alu_invalid),
    .op_count     (op_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: add/sub flag signed overflow, addu flags carry-out.
  always_comb begin
    mRes  = 32'h0;
    mOvf  = 1'b0;
    mInv  = 1'b0;
    mWide = 33'h0;
    case (alu_control)
      4'h2: begin
        mRes = alu_a + alu_b;
        mOvf = (alu_a[31] == alu_b[31]) && (mRes[31] != alu_a[31]);
      end
      4'h3: begin
        mWide = {1'b0, alu_a} + {1'b0, alu_b};
        mRes  = mWide[31:0];
        mOvf  = mWide[32];
      end
      4'h6: begin
        mRes = alu_a - alu_b;
        mOvf = (alu_a[31] != alu_b[31]) && (mRes[31] != alu_a[31]);
      end
      4'h0: mRes = alu_a & alu_b;
      4'h1: mRes = alu_a | alu_b;
      4'hC: mRes = ~(alu_a | alu_b);
      4'h7: mRes = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: mInv = 1'b1;
    endcase
  end

  // Register the ALU outputs one cycle after sampling its inputs.
  always @(posedge clock) begin
    alu_result   <= mRes;
    alu_zero     <= (mRes == 32'h0);
    alu_overflow <= mOvf;
    alu_invalid  <= mInv | injInvalid;
  end

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        inj;
    logic [3:0]  expCtrl;
    logic        expErr;
    logic [31:0] expResult;
    logic        expZero;
    logic        expOvf;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one request, accept it, and return how many edges until out_valid (0 on timeout).
  task automatic applyStimulus(input logic [5:0] opcode, input logic [5:0] funct,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic inj, input logic earlyReady, output int lat);
    @(negedge clock);
    bus.in_opcode = opcode;
    bus.in_funct  = funct;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_valid  = 1'b1;
    injInvalid    = inj;
    checkOutput("in_ready_idle", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clock);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = earlyReady;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finishResponse();
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    injInvalid    = 1'b0;
    expCount++;
    checkOutput("op_count", {30'b0, op_count}, expCount % 4);
  endtask

  initial begin
    int lat;
    logic [31:0] holdResult;
    vectorsApplied = 0;
    miscompares    = 0;
    expCount       = 0;
    injInvalid     = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_opcode  = 6'h0;
    bus.in_funct   = 6'h0;
    bus.in_a       = 32'h0;
    bus.in_b       = 32'h0;
    bus.out_ready  = 1'b0;
    reset          = 1'b1;

    //                    opc    fun    a             b             inj  ctrl  err   result        z     o     lat
    vecs.push_back(vec_t'{6'h00, 6'h20, 32'd5,        32'd7,        1'b0, 4'h2, 1'b0, 32'd12,       1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h00, 6'h20, 32'h7FFFFFFF, 32'd1,        1'b0, 4'h2, 1'b0, 32'h80000000, 1'b0, 1'b1, 3});
    vecs.push_back(vec_t'{6'h00, 6'h21, 32'hFFFFFFFF, 32'd1,        1'b0, 4'h3, 1'b0, 32'h0,        1'b1, 1'b0, 3});
    vecs.push_back(vec_t'{6'h00, 6'h22, 32'h80000000, 32'd1,        1'b0, 4'h6, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 3});
    vecs.push_back(vec_t'{6'h00, 6'h23, 32'h80000000, 32'd1,        1'b0, 4'h6, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h00, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 4'h0, 1'b0, 32'h00F000F0, 1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h00, 6'h25, 32'hF0F0F0F0, 32'h0F0F0000, 1'b0, 4'h1, 1'b0, 32'hFFFFF0F0, 1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h00, 6'h27, 32'h0,        32'hFFFF0000, 1'b0, 4'hC, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        1'b0, 4'h7, 1'b0, 32'd1,        1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h3F, 6'h20, 32'd1,        32'd1,        1'b0, 4'h7, 1'b1, 32'h0,        1'b0, 1'b0, 1});
    vecs.push_back(vec_t'{6'h08, 6'h3F, 32'h0000000A, 32'hFFFFFFF6, 1'b0, 4'h2, 1'b0, 32'h0,        1'b1, 1'b0, 3});
    vecs.push_back(vec_t'{6'h09, 6'h3F, 32'h7FFFFFFF, 32'd1,        1'b0, 4'h3, 1'b0, 32'h80000000, 1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h0C, 6'h3F, 32'h12345678, 32'h0000FFFF, 1'b0, 4'h0, 1'b0, 32'h00005678, 1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h0D, 6'h3F, 32'h12340000, 32'h00005678, 1'b0, 4'h1, 1'b0, 32'h12345678, 1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h00, 6'h26, 32'd3,        32'd3,        1'b0, 4'h1, 1'b1, 32'h0,        1'b0, 1'b0, 1});
    vecs.push_back(vec_t'{6'h0A, 6'h3F, 32'd5,        32'd3,        1'b0, 4'h7, 1'b0, 32'h0,        1'b1, 1'b0, 3});
    vecs.push_back(vec_t'{6'h04, 6'h3F, 32'd9,        32'd9,        1'b0, 4'h6, 1'b0, 32'h0,        1'b1, 1'b0, 3});
    vecs.push_back(vec_t'{6'h05, 6'h3F, 32'd9,        32'd4,        1'b0, 4'h6, 1'b0, 32'd5,        1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h23, 6'h3F, 32'h1000,     32'd4,        1'b0, 4'h2, 1'b0, 32'h1004,     1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h2B, 6'h3F, 32'h2000,     32'hFFFFFFFC, 1'b0, 4'h2, 1'b0, 32'h1FFC,     1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h00, 6'h20, 32'd1,        32'd2,        1'b1, 4'h2, 1'b1, 32'd3,        1'b0, 1'b0, 3});
    vecs.push_back(vec_t'{6'h02, 6'h00, 32'd1,        32'd2,        1'b0, 4'h2, 1'b1, 32'h0,        1'b0, 1'b0, 1});

    // Reset values while reset is held.
    #2;
    checkOutput("rst_alu_a",     alu_a,                      32'h0);
    checkOutput("rst_alu_ctrl",  {28'b0, alu_control},       32'h0);
    checkOutput("rst_out_valid", {31'b0, bus.out_valid},     32'h0);
    checkOutput("rst_out_error", {31'b0, bus.out_error},     32'h0);
    checkOutput("rst_op_count",  {30'b0, op_count},          32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("in_ready_after_rst", {31'b0, bus.in_ready}, 32'd1);

    // Table-driven vectors; odd rows hold out_ready high before the response appears.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].opcode, vecs[i].funct, vecs[i].a, vecs[i].b,
                    vecs[i].inj, 1'(i % 2), lat);
      checkOutput($sformatf("v%0d_latency", i),  lat,                           vecs[i].expLat);
      checkOutput($sformatf("v%0d_alu_ctrl", i), {28'b0, alu_control},         {28'b0, vecs[i].expCtrl});
      checkOutput($sformatf("v%0d_result", i),   bus.out_result,                vecs[i].expResult);
      checkOutput($sformatf("v%0d_zero", i),     {31'b0, bus.out_zero},         {31'b0, vecs[i].expZero});
      checkOutput($sformatf("v%0d_ovf", i),      {31'b0, bus.out_overflow},     {31'b0, vecs[i].expOvf});
      checkOutput($sformatf("v%0d_err", i),      {31'b0, bus.out_error},        {31'b0, vecs[i].expErr});
      finishResponse();
    end

    // Backpressure: response held for 5 cycles while a stray request is ignored.
    applyStimulus(6'h00, 6'h25, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0, lat);
    checkOutput("bp_latency", lat, 32'd3);
    holdResult = bus.out_result;
    checkOutput("bp_result", holdResult, 32'h000000FF);
    bus.in_valid  = 1'b1;
    bus.in_opcode = 6'h00;
    bus.in_funct  = 6'h20;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checkOutput("bp_hold_result", bus.out_result,          32'h000000FF);
      checkOutput("bp_hold_valid",  {31'b0, bus.out_valid},  32'd1);
      checkOutput("bp_in_ready",    {31'b0, bus.in_ready},   32'd0);
    end
    bus.in_valid = 1'b0;
    finishResponse();
    @(negedge clock);
    checkOutput("bp_in_ready_after", {31'b0, bus.in_ready},  32'd1);
    checkOutput("bp_valid_after",    {31'b0, bus.out_valid}, 32'd0);

    // Reset asserted while the operation sits in CAPTURE.
    @(negedge clock);
    bus.in_opcode = 6'h00;
    bus.in_funct  = 6'h20;
    bus.in_a      = 32'd3;
    bus.in_b      = 32'd4;
    bus.in_valid  = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_alu_a",     alu_a,                   32'h0);
    checkOutput("mid_rst_alu_b",     alu_b,                   32'h0);
    checkOutput("mid_rst_alu_ctrl",  {28'b0, alu_control},    32'h0);
    checkOutput("mid_rst_out_valid", {31'b0, bus.out_valid},  32'h0);
    checkOutput("mid_rst_result",    bus.out_result,          32'h0);
    checkOutput("mid_rst_op_count",  {30'b0, op_count},       32'h0);
    expCount = 0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_rst_in_ready", {31'b0, bus.in_ready},   32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checkOutput("post_rst_no_valid", {31'b0, bus.out_valid}, 32'd0);
    end

    // Normal operation resumes with the count restarting from zero.
    applyStimulus(6'h00, 6'h20, 32'd5, 32'd7, 1'b0, 1'b0, lat);
    checkOutput("post_rst_latency", lat,            32'd3);
    checkOutput("post_rst_result",  bus.out_result, 32'd12);
    finishResponse();

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: COUNT_WIDTH, 16, width of the completed-operation counter.
REQ-002 clock  in  1  single clock; all state updates on its posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  request valid.
REQ-005 in_ready  out  1  request accepted when in_valid & in_ready at a posedge.
REQ-006 in_opcode  in  6  MIPS opcode field.
REQ-007 in_funct  in  6  MIPS funct field; used only when in_opcode == 6'h00.
REQ-008 in_a, in_b  in  32 each  operands; in_b already sign/zero-extended upstream.
REQ-009 alu_a, alu_b  out  32 each  registered operands to the ALU.
REQ-010 alu_control  out  4  registered ALU control code.
REQ-011 alu_result  in  32  registered ALU result; valid one cycle after the ALU samples its inputs.
REQ-012 alu_zero, alu_overflow, alu_invalid  in  1 each  ALU flags.
REQ-013 out_valid  out  1  response valid; out_ready  in  1  response accepted.
REQ-014 out_result  out  32; out_zero, out_overflow, out_error  out  1 each.
REQ-015 op_count  out  COUNT_WIDTH  number of completed responses.

Function
REQ-016 Decode R-type (opcode 6'h00), funct->control: 20->2, 21->3, 22->6, 23->6, 24->0, 25->1, 27->C, 2A->7.
REQ-017 Decode I-type, opcode->control: 08->2, 09->3, 0C->0, 0D->1, 0A->7, 04->6, 05->6, 23->2, 2B->2.
REQ-018 Any other opcode/funct SHALL be a decode error.
REQ-019 FSM states: IDLE, EXEC, CAPTURE, RESP.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 IDLE, accept, valid decode: register in_a/in_b/control onto alu_a/alu_b/alu_control -> EXEC.
REQ-022 IDLE, accept, decode error: alu_* SHALL remain unchanged; out_result=0, out_zero=0, out_overflow=0, out_error=1 -> RESP.
REQ-023 EXEC: unconditional -> CAPTURE (the ALU samples alu_* at this edge).
REQ-024 CAPTURE: out_result<=alu_result, out_zero<=alu_zero, out_error<=alu_invalid -> RESP.
REQ-025 out_overflow SHALL equal alu_overflow, except forced 0 when the issued control is 4'h3 or the instruction is subu (funct 23).
REQ-026 RESP: out_valid=1; out_* SHALL be held stable until out_valid & out_ready at a posedge, then -> IDLE.
REQ-027 Latency: out_valid SHALL rise 3 posedges after acceptance for a valid op and 1 posedge after acceptance for a decode error.
REQ-028 Throughput: at most one request in flight; the next acceptance SHALL occur no earlier than the edge after the response handshake.
REQ-029 op_count SHALL increment by 1 on each response handshake, including decode errors, and SHALL wrap from all-ones to 0.
REQ-030 out_ready held high before RESP SHALL have no effect; in_valid outside IDLE SHALL be ignored.
REQ-031 alu_a, alu_b and alu_control SHALL hold their last issued values outside EXEC.

Reset
REQ-032 reset SHALL force state=IDLE, alu_a=0, alu_b=0, alu_control=4'h0, out_valid=0, out_result=0, out_zero=0, out_overflow=0, out_error=0, op_count=0, asynchronously.
REQ-033 A reset in any state SHALL abandon the in-flight operation with no response and no count increment.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 add: opcode 00, funct 20, a=5, b=7 -> alu_control=2; out_valid 3 cycles after acceptance; out_result=12, zero=0, overflow=0, error=0; op_count=1.
REQ-036 Overflow masking: add with a=32'h7FFFFFFF, b=1 -> out_overflow=1; addu (funct 21) with a=32'hFFFFFFFF, b=1 -> out_result=0, out_zero=1, out_overflow=0.
REQ-037 Decode error: opcode 6'h3F -> out_valid 1 cycle after acceptance, out_error=1, out_result=0; alu_control unchanged from the previous op.
REQ-038 Backpressure: out_ready=0 for 5 cycles in RESP -> out_* stable and in_ready=0 throughout; on handshake, in_ready=1 on the next cycle.
REQ-039 Reset mid-op: assert reset in CAPTURE -> all outputs at reset values immediately, no out_valid, op_count=0.
REQ-040 Wrap: with COUNT_WIDTH=2, complete 4 ops -> op_count sequence 1, 2, 3, 0.
